// File: rtl/rv_pkg.sv
// Shared constants and types for the RV32I integer register file.
package rv_pkg;

   localparam int XLEN       = 32;
   localparam int NUM_REGS   = 32;
   localparam int REG_ADDR_W = $clog2(NUM_REGS);

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;
   typedef logic [XLEN-1:0]       xlen_t;

   // x0 is the architectural zero register.
   localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: index mux, optional same-cycle write bypass,
// and x0 forced to zero.
module regfile_read_port #(
   parameter int XLEN     = rv_pkg::XLEN,
   parameter int NUM_REGS = rv_pkg::NUM_REGS,
   parameter int ADDR_W   = rv_pkg::REG_ADDR_W,
   parameter bit BYPASS   = 1'b0
) (
   input  logic [XLEN-1:0]   regs [NUM_REGS],
   input  logic [ADDR_W-1:0] idx,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_idx,
   input  logic [XLEN-1:0]   wr_data,
   output logic [XLEN-1:0]   data
);
   import rv_pkg::REG_ZERO;

   logic bypass_hit;
   logic is_zero;

   assign bypass_hit = BYPASS && wr_en && (wr_idx == idx);
   assign is_zero    = (idx == ADDR_W'(REG_ZERO));

   // Zero-forcing is applied last so a write aimed at x0 can never leak
   // through the bypass path.
   always_comb begin
      data = regs[idx];
      if (bypass_hit) data = wr_data;
      if (is_zero)    data = '0;
   end

endmodule

// File: rtl/rv32_register_file.sv
// RV32I integer register file: 32 x XLEN, two async read ports, one
// synchronous write port, x0 hardwired to zero.
module rv32_register_file #(
   parameter int XLEN         = rv_pkg::XLEN,
   parameter int NUM_REGS     = rv_pkg::NUM_REGS,
   parameter int ADDR_W       = rv_pkg::REG_ADDR_W,
   parameter bit WRITE_BYPASS = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] Write_register,
   input  logic [XLEN-1:0]   Write_data,
   input  logic [ADDR_W-1:0] Read_register1,
   input  logic [ADDR_W-1:0] Read_register2,
   output logic [XLEN-1:0]   Read_data1,
   output logic [XLEN-1:0]   Read_data2
);
   import rv_pkg::REG_ZERO;

   logic [XLEN-1:0] regs [NUM_REGS];
   logic            wr_fire;

   assign wr_fire = RegWrite && (Write_register != ADDR_W'(REG_ZERO));

   // NOTE: sequential state is always assigned with <= so every register
   // samples pre-edge values; blocking here would create ordering races.
   // NOTE: the array is cleared on reset because software may read any
   // register right after reset and must see 0; this keeps it in flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wr_fire) begin
         regs[Write_register] <= Write_data;
      end
   end

   regfile_read_port #(
      .XLEN     (XLEN),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .BYPASS   (WRITE_BYPASS)
   ) u_rd_port1 (
      .regs    (regs),
      .idx     (Read_register1),
      .wr_en   (RegWrite),
      .wr_idx  (Write_register),
      .wr_data (Write_data),
      .data    (Read_data1)
   );

   regfile_read_port #(
      .XLEN     (XLEN),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .BYPASS   (WRITE_BYPASS)
   ) u_rd_port2 (
      .regs    (regs),
      .idx     (Read_register2),
      .wr_en   (RegWrite),
      .wr_idx  (Write_register),
      .wr_data (Write_data),
      .data    (Read_data2)
   );

endmodule

// File: tb/tb_rv32_register_file.sv
// Scoreboard bench for rv32_register_file; drives one instance without and
// one with write bypass from the same stimulus.
module tb_rv32_register_file;
   import rv_pkg::*;

   logic     clk = 1'b0;
   logic     reset;
   logic     we;
   reg_idx_t wa, r1, r2;
   xlen_t    wd;
   xlen_t    nb1, nb2, bp1, bp2;

   typedef struct {
      string name;
      xlen_t val;
   } exp_t;

   exp_t  sb_q [$];
   xlen_t obs_q [$];
   xlen_t model [NUM_REGS];
   int    vectors     = 0;
   int    miscompares = 0;

   always #5 clk = ~clk;

   rv32_register_file #(.WRITE_BYPASS(1'b0)) dut_nb (
      .clk            (clk),
      .reset          (reset),
      .RegWrite       (we),
      .Write_register (wa),
      .Write_data     (wd),
      .Read_register1 (r1),
      .Read_register2 (r2),
      .Read_data1     (nb1),
      .Read_data2     (nb2)
   );

   rv32_register_file #(.WRITE_BYPASS(1'b1)) dut_bp (
      .clk            (clk),
      .reset          (reset),
      .RegWrite       (we),
      .Write_register (wa),
      .Write_data     (wd),
      .Read_register1 (r1),
      .Read_register2 (r2),
      .Read_data1     (bp1),
      .Read_data2     (bp2)
   );

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at %0t, limit 200000", $time);
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string n, input xlen_t v);
      exp_t e;
      e.name = n;
      e.val  = v;
      sb_q.push_back(e);
   endtask

   task automatic write_reg(input reg_idx_t a, input xlen_t d);
      we = 1'b1; wa = a; wd = d;
      step();
      if (a != 0) model[a] = d;
      we = 1'b0;
   endtask

   // Drive both read indices and queue the expected values for both instances.
   task automatic expect_reads(input string tag, input reg_idx_t a1, input reg_idx_t a2);
      r1 = a1; r2 = a2;
      push({tag, " nb.rd1"}, model[a1]);
      push({tag, " nb.rd2"}, model[a2]);
      push({tag, " bp.rd1"}, model[a1]);
      push({tag, " bp.rd2"}, model[a2]);
   endtask

   task automatic capture();
      #1;
      obs_q.push_back(nb1);
      obs_q.push_back(nb2);
      obs_q.push_back(bp1);
      obs_q.push_back(bp2);
   endtask

   task automatic test_reset();
      reset = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'h0000_0005;
      step();
      reset = 1'b0; we = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      expect_reads("reset x0/x1", 5'd0, 5'd1);  capture();
      expect_reads("reset x1/x19", 5'd1, 5'd19); capture();
      expect_reads("reset x3", 5'd3, 5'd31);   capture();
      while (obs_q.size() > 0) begin
         exp_t  e;
         xlen_t o;
         o = obs_q.pop_front();
         vectors++;
         if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: observed %h with nothing expected", o);
         end else begin
            e = sb_q.pop_front();
            if (o !== e.val) begin
               miscompares++;
               $display("FAIL %s: observed %h, expected %h", e.name, o, e.val);
            end
         end
      end
   endtask

   task automatic test_single_write();
      write_reg(5'd25, 32'd1025);
      expect_reads("write x25", 5'd25, 5'd25); capture();
      push("write x25 const nb.rd1", 32'd1025);
      obs_q.push_back(nb1);
      while (obs_q.size() > 0) begin
         exp_t  e;
         xlen_t o;
         o = obs_q.pop_front();
         vectors++;
         if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: observed %h with nothing expected", o);
         end else begin
            e = sb_q.pop_front();
            if (o !== e.val) begin
               miscompares++;
               $display("FAIL %s: observed %h, expected %h", e.name, o, e.val);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      write_reg(5'd10, 32'd100025);
      write_reg(5'd12, 32'd6545);
      expect_reads("b2b x10/x12", 5'd10, 5'd12); capture();
      expect_reads("b2b x25/x0", 5'd25, 5'd0);   capture();
      for (int k = 1; k <= 4; k++) write_reg(reg_idx_t'(k), 32'h1111_0000 * k + 32'(k));
      expect_reads("b2b x1/x4", 5'd1, 5'd4); capture();
      expect_reads("b2b x2/x3", 5'd2, 5'd3); capture();
      while (obs_q.size() > 0) begin
         exp_t  e;
         xlen_t o;
         o = obs_q.pop_front();
         vectors++;
         if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: observed %h with nothing expected", o);
         end else begin
            e = sb_q.pop_front();
            if (o !== e.val) begin
               miscompares++;
               $display("FAIL %s: observed %h, expected %h", e.name, o, e.val);
            end
         end
      end
   endtask

   task automatic test_write_enable();
      we = 1'b0; wa = 5'd10; wd = 32'd7;
      step();
      expect_reads("we=0 x10", 5'd10, 5'd10); capture();
      we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF;
      step();
      we = 1'b0;
      expect_reads("x0 write", 5'd0, 5'd0); capture();
      push("x0 write const rd1", 32'd0);
      obs_q.push_back(nb1);
      while (obs_q.size() > 0) begin
         exp_t  e;
         xlen_t o;
         o = obs_q.pop_front();
         vectors++;
         if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: observed %h with nothing expected", o);
         end else begin
            e = sb_q.pop_front();
            if (o !== e.val) begin
               miscompares++;
               $display("FAIL %s: observed %h, expected %h", e.name, o, e.val);
            end
         end
      end
   endtask

   task automatic test_bypass();
      r1 = 5'd12; r2 = 5'd12;
      we = 1'b1; wa = 5'd12; wd = 32'd42;
      push("pre-edge x12 nb.rd1", 32'd6545);
      push("pre-edge x12 nb.rd2", 32'd6545);
      push("pre-edge x12 bp.rd1", 32'd42);
      push("pre-edge x12 bp.rd2", 32'd42);
      capture();
      step();
      model[12] = 32'd42;
      we = 1'b0;
      expect_reads("post-edge x12", 5'd12, 5'd12); capture();
      r1 = 5'd0; r2 = 5'd0;
      we = 1'b1; wa = 5'd0; wd = 32'hDEAD_0000;
      push("x0 bypass nb.rd1", 32'd0);
      push("x0 bypass nb.rd2", 32'd0);
      push("x0 bypass bp.rd1", 32'd0);
      push("x0 bypass bp.rd2", 32'd0);
      capture();
      step();
      we = 1'b0;
      while (obs_q.size() > 0) begin
         exp_t  e;
         xlen_t o;
         o = obs_q.pop_front();
         vectors++;
         if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: observed %h with nothing expected", o);
         end else begin
            e = sb_q.pop_front();
            if (o !== e.val) begin
               miscompares++;
               $display("FAIL %s: observed %h, expected %h", e.name, o, e.val);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      reset = 1'b1; we = 1'b1; wa = 5'd5; wd = 32'd99;
      step();
      reset = 1'b0; we = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      expect_reads("mid-reset x5/x10", 5'd5, 5'd10);  capture();
      expect_reads("mid-reset x12/x25", 5'd12, 5'd25); capture();
      write_reg(5'd7, 32'hDEAD_BEEF);
      expect_reads("after reset x7/x5", 5'd7, 5'd5); capture();
      while (obs_q.size() > 0) begin
         exp_t  e;
         xlen_t o;
         o = obs_q.pop_front();
         vectors++;
         if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: observed %h with nothing expected", o);
         end else begin
            e = sb_q.pop_front();
            if (o !== e.val) begin
               miscompares++;
               $display("FAIL %s: observed %h, expected %h", e.name, o, e.val);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b0; we = 1'b0; wa = '0; wd = '0; r1 = '0; r2 = '0;
      step();
      test_reset();
      test_single_write();
      test_back_to_back();
      test_write_enable();
      test_bypass();
      test_reset_mid();
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_leftover: observed %0d entries remaining, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rv32_register_file.md
Name: rv32_register_file

Overview:
- RV32I integer register file for the single-cycle RISC-V core: 32 registers × 32 bits, x0 hardwired to zero.
- Two asynchronous (combinational) read ports feed the ALU operands (rs1, rs2).
- One synchronous write port is driven from the writeback stage (rd).
- Sits between instruction decode (register indices) and execute/writeback.

Parameters:
- XLEN, 32, data width of each register and of all data ports.
- NUM_REGS, 32, number of architectural registers.
- ADDR_W, 5, register index width; must equal clog2(NUM_REGS).
- WRITE_BYPASS, 0, when 1 a read of the register being written this cycle returns Write_data combinationally; when 0 it returns the stored (old) value.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- RegWrite  input  1  write enable for the write port.
- Write_register  input  ADDR_W  destination index (rd, instr[11:7]).
- Write_data  input  XLEN  data to write.
- Read_register1  input  ADDR_W  source index 1 (rs1, instr[19:15]).
- Read_register2  input  ADDR_W  source index 2 (rs2, instr[24:20]).
- Read_data1  output  XLEN  contents of register Read_register1.
- Read_data2  output  XLEN  contents of register Read_register2.

Behaviour:
- Reset: on a rising clk with reset=1, all registers x0..x31 become 0. Reset has priority over a concurrent write, which is dropped. Reset mid-operation takes effect at that edge only; there is no partial clearing.
- Write: on a rising clk with reset=0, RegWrite=1 and Write_register≠0, reg[Write_register] <= Write_data. Latency is 1 edge; the new value is visible on the read ports immediately after that edge.
- Writes with Write_register=0 are ignored.
- RegWrite=0 leaves all registers unchanged.
- Reads are combinational, with zero-cycle latency: Read_dataN = reg[Read_registerN]. A read of index 0 always returns 0.
- Both read ports are independent and may address the same register; both return the same value.
- Simultaneous read and write of the same index (index≠0):
  - WRITE_BYPASS=0: the read returns the old value until the edge.
  - WRITE_BYPASS=1: the read returns Write_data while RegWrite=1.
- Outputs after reset: both Read_data ports read 0 for every index.
- There are no X outputs after the first reset edge; before the first reset, contents are undefined. x0 reads 0 regardless of reset.
- No handshake and no stall; one write per cycle maximum.

Decomposition:
- Shared package (rv_pkg):
  - XLEN, NUM_REGS and REG_ADDR_W constants.
  - typedef reg_idx_t (ADDR_W bits).
  - typedef xlen_t (XLEN bits).
  - constant REG_ZERO = 0.
- One natural sub-module, regfile_read_port: index → data mux with the x0 zero-forcing and optional bypass compare. It is instantiated twice in the top, once per read port.

Test Plan:
- Pulse reset for 1 edge, then read Read_register1=0, Read_register2=1 -> Read_data1=0, Read_data2=0. Read rs1=1, rs2=19 -> both 0.
- RegWrite=1, Write_register=25, Write_data=1025; after the edge, Read_register1=25 -> Read_data1=1025. Read_register2=25 -> 1025 on the second port as well.
- Write x10=100025, then write x12=6545; read rs1=10, rs2=12 -> Read_data1=100025, Read_data2=6545. x25 still reads 1025.
- Write-enable and x0 checks:
  - RegWrite=0, Write_register=10, Write_data=7 -> x10 remains 100025.
  - RegWrite=1, Write_register=0, Write_data=0xFFFFFFFF -> reading index 0 on both ports returns 0.
- Same-cycle write/read of x12 with Write_data=42:
  - WRITE_BYPASS=0: the port shows 6545 before the edge and 42 after.
  - WRITE_BYPASS=1: the port shows 42 before the edge.
- Reset mid-operation: after x10, x12 and x25 are loaded, assert reset together with RegWrite=1 to x5=99 -> after the edge, all reads (x5, x10, x12, x25) return 0.
